// File: rtl/idct_mul_seq_driver.sv
// idct_mul_seq_driver: initiator side of the IDCT multiplier-wrapper protocol.
// Streams 128 operand pairs per frame (ROW pass then COL pass) to the wrapper,
// sums every 8 returned products into one dot-product result, and queues the
// results in a 2-entry valid/ready FIFO.
// Ports:
//   clk, rstP              clock, synchronous active-high reset
//   start, apx_cfg         frame start pulse, approximate-mode request (latched at start)
//   in_valid/in_ready      operand pair handshake, in_a/in_b signed operands
//   mul_a/mul_b            left-aligned operands to the wrapper (registered)
//   mul_state/mul_count0   wrapper state code and pair index (registered)
//   mul_racc/mul_rapx      wrapper accurate reset / approximate enable (registered)
//   mul_vld                pair issued this cycle
//   mul_p                  signed product, MUL_LAT cycles after mul_vld
//   res_valid/res_ready    result handshake, res_data sum of 8, res_last frame end
//   busy, done             FSM not idle, 1-cycle pulse at frame end
`timescale 1ns/1ps
module idct_mul_seq_driver #(
  parameter int unsigned OP_BITWIDTH        = 16,
  parameter int unsigned DATA_PATH_BITWIDTH = 24,
  parameter int unsigned MUL_LAT            = 3,
  parameter int unsigned ACC_W              = 35
) (
  input  logic                          clk,
  input  logic                          rstP,
  input  logic                          start,
  input  logic                          apx_cfg,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [OP_BITWIDTH-1:0]        in_a,
  input  logic [OP_BITWIDTH-1:0]        in_b,
  output logic [DATA_PATH_BITWIDTH-1:0] mul_a,
  output logic [DATA_PATH_BITWIDTH-1:0] mul_b,
  output logic [2:0]                    mul_state,
  output logic [8:0]                    mul_count0,
  output logic                          mul_racc,
  output logic                          mul_rapx,
  output logic                          mul_vld,
  input  logic [31:0]                   mul_p,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [ACC_W-1:0]              res_data,
  output logic                          res_last,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned PadW = DATA_PATH_BITWIDTH - OP_BITWIDTH;

  typedef enum logic [2:0] {
    StIdle  = 3'b000,
    StPrime = 3'b001,
    StRow   = 3'b010,
    StCol   = 3'b011,
    StDrain = 3'b100
  } state_e;

  state_e                        state_q, state_d;
  logic                          apx_q, apx_d;
  logic [8:0]                    count0_q, count0_d;
  logic [DATA_PATH_BITWIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic                          mul_vld_q, mul_vld_d;
  logic                          iss_ge_q, iss_ge_d, iss_fe_q, iss_fe_d;
  logic                          racc_q, racc_d, rapx_q, rapx_d;
  logic                          done_q, done_d;
  logic [MUL_LAT-1:0]            tag_vld_q, tag_vld_d, tag_ge_q, tag_ge_d, tag_fe_q, tag_fe_d;
  logic [ACC_W-1:0]              acc_q, acc_d;
  logic [ACC_W-1:0]              fifo_data_q [2];
  logic [ACC_W-1:0]              fifo_data_d [2];
  logic [1:0]                    fifo_last_q, fifo_last_d;
  logic [1:0]                    fifo_cnt_q, fifo_cnt_d;

  logic [7:0]       closing;
  logic             accept, pass_end;
  logic [8:0]       idx;
  logic [ACC_W-1:0] prod_ext, sum;
  logic             push, pop;
  logic [1:0]       wr_idx;

  // Groups already committed to closing each need a FIFO slot when they exit
  always_comb begin
    closing = {7'b0, mul_vld_q & iss_ge_q};
    for (int i = 0; i < int'(MUL_LAT); i++) begin
      closing = closing + {7'b0, tag_vld_q[i] & tag_ge_q[i]};
    end
  end

  assign in_ready = ((state_q == StRow) || (state_q == StCol)) &&
                    (({6'b0, fifo_cnt_q} + closing) < 8'd2);
  assign accept   = in_valid & in_ready;
  // PRIME parks count0 at 63 so the first accept of each pass lands on index 0
  assign idx      = (count0_q == 9'd63) ? 9'd0 : count0_q + 9'd1;
  assign pass_end = accept && (idx == 9'd63);

  // FSM and issue stage
  always_comb begin
    state_d   = state_q;
    apx_d     = apx_q;
    count0_d  = count0_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    done_d    = 1'b0;
    mul_vld_d = accept;
    iss_ge_d  = accept && (idx[2:0] == 3'd7);
    iss_fe_d  = pass_end && (state_q == StCol);
    if (accept) begin
      mul_a_d  = DATA_PATH_BITWIDTH'(in_a) << PadW;
      mul_b_d  = DATA_PATH_BITWIDTH'(in_b) << PadW;
      count0_d = idx;
    end
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StPrime;
          apx_d    = apx_cfg;
          count0_d = 9'd63;
        end
      end
      StPrime: state_d = StRow;
      StRow:   if (pass_end) state_d = StCol;
      StCol:   if (pass_end) state_d = StDrain;
      StDrain: begin
        if (!mul_vld_q && (tag_vld_q == '0)) begin
          state_d  = StIdle;
          done_d   = 1'b1;
          count0_d = 9'd0;
        end
      end
      default: state_d = StIdle;
    endcase
    racc_d = (state_d == StIdle);
    rapx_d = apx_d && ((state_d == StRow) || (state_d == StCol) || (state_d == StDrain));
  end

  // Tag pipe aligns each issued pair with its product on mul_p
  always_comb begin
    tag_vld_d[0] = mul_vld_q;
    tag_ge_d[0]  = iss_ge_q;
    tag_fe_d[0]  = iss_fe_q;
    for (int i = 1; i < int'(MUL_LAT); i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_ge_d[i]  = tag_ge_q[i-1];
      tag_fe_d[i]  = tag_fe_q[i-1];
    end
  end

  // Accumulate and close groups
  assign prod_ext = {{(ACC_W-32){mul_p[31]}}, mul_p};
  assign sum      = acc_q + prod_ext;

  always_comb begin
    acc_d = acc_q;
    push  = 1'b0;
    if (tag_vld_q[MUL_LAT-1]) begin
      if (tag_ge_q[MUL_LAT-1]) begin
        push  = 1'b1;
        acc_d = '0;
      end else begin
        acc_d = sum;
      end
    end
  end

  // 2-entry FIFO, head always in slot 0
  assign res_valid = (fifo_cnt_q != 2'd0);
  assign pop       = res_valid & res_ready;
  assign wr_idx    = fifo_cnt_q - {1'b0, pop};

  always_comb begin
    fifo_data_d[0] = fifo_data_q[0];
    fifo_data_d[1] = fifo_data_q[1];
    fifo_last_d    = fifo_last_q;
    fifo_cnt_d     = fifo_cnt_q;
    if (pop) begin
      fifo_data_d[0] = fifo_data_q[1];
      fifo_last_d[0] = fifo_last_q[1];
    end
    if (push) begin
      if (wr_idx == 2'd0) begin
        fifo_data_d[0] = sum;
        fifo_last_d[0] = tag_fe_q[MUL_LAT-1];
      end else begin
        fifo_data_d[1] = sum;
        fifo_last_d[1] = tag_fe_q[MUL_LAT-1];
      end
    end
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + 2'd1;
    end else if (pop && !push) begin
      fifo_cnt_d = fifo_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rstP) begin
      state_q        <= StIdle;
      apx_q          <= 1'b0;
      count0_q       <= '0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
      mul_vld_q      <= 1'b0;
      iss_ge_q       <= 1'b0;
      iss_fe_q       <= 1'b0;
      racc_q         <= 1'b1;
      rapx_q         <= 1'b0;
      done_q         <= 1'b0;
      tag_vld_q      <= '0;
      tag_ge_q       <= '0;
      tag_fe_q       <= '0;
      acc_q          <= '0;
      fifo_data_q[0] <= '0;
      fifo_data_q[1] <= '0;
      fifo_last_q    <= '0;
      fifo_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      apx_q          <= apx_d;
      count0_q       <= count0_d;
      mul_a_q        <= mul_a_d;
      mul_b_q        <= mul_b_d;
      mul_vld_q      <= mul_vld_d;
      iss_ge_q       <= iss_ge_d;
      iss_fe_q       <= iss_fe_d;
      racc_q         <= racc_d;
      rapx_q         <= rapx_d;
      done_q         <= done_d;
      tag_vld_q      <= tag_vld_d;
      tag_ge_q       <= tag_ge_d;
      tag_fe_q       <= tag_fe_d;
      acc_q          <= acc_d;
      fifo_data_q[0] <= fifo_data_d[0];
      fifo_data_q[1] <= fifo_data_d[1];
      fifo_last_q    <= fifo_last_d;
      fifo_cnt_q     <= fifo_cnt_d;
    end
  end

  assign mul_state  = state_q;
  assign mul_count0 = count0_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_vld    = mul_vld_q;
  assign mul_racc   = racc_q;
  assign mul_rapx   = rapx_q;
  assign res_data   = fifo_data_q[0];
  assign res_last   = fifo_last_q[0];
  assign busy       = (state_q != StIdle);
  assign done       = done_q;

endmodule

// File: tb/tb_idct_mul_seq_driver.sv
// Bench for idct_mul_seq_driver: models the multiplier wrapper (3-cycle product
// of the left-aligned operands), drives frames from a table of operand groups
// and checks results through a scoreboard queue.
`timescale 1ns/1ps
module tb_idct_mul_seq_driver;

  logic        clk = 1'b0;
  logic        rstP, start, apx_cfg, in_valid, in_ready;
  logic [15:0] in_a, in_b;
  logic [23:0] mul_a, mul_b;
  logic [2:0]  mul_state;
  logic [8:0]  mul_count0;
  logic        mul_racc, mul_rapx, mul_vld;
  logic [31:0] mul_p;
  logic        res_valid, res_ready, res_last, busy, done;
  logic [34:0] res_data;

  always #5 clk = ~clk;

  idct_mul_seq_driver dut (
    .clk(clk), .rstP(rstP), .start(start), .apx_cfg(apx_cfg),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_state(mul_state), .mul_count0(mul_count0),
    .mul_racc(mul_racc), .mul_rapx(mul_rapx), .mul_vld(mul_vld), .mul_p(mul_p),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .busy(busy), .done(done)
  );

  // Wrapper model: P = a*b of the operand fields, MUL_LAT=3 cycles after issue
  logic signed [15:0] wa, wb;
  logic signed [31:0] wa32, wb32;
  logic [31:0]        p_pipe [3];
  assign wa    = mul_a[23:8];
  assign wb    = mul_b[23:8];
  assign wa32  = wa;
  assign wb32  = wb;
  assign mul_p = p_pipe[2];
  always @(posedge clk) begin
    p_pipe[0] <= wa32 * wb32;
    p_pipe[1] <= p_pipe[0];
    p_pipe[2] <= p_pipe[1];
  end

  typedef struct {
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic signed [34:0] exp;
  } vec_t;
  typedef struct {
    logic [34:0] data;
    logic        last;
  } exp_t;

  vec_t tbl [8];
  exp_t sb_q [$];

  int n_tests = 0;
  int n_fail  = 0;
  int st_cnt [8];
  int done_cnt, res_cnt, last_cnt, vld_cnt;
  int vld_err = 0;
  int apx_err = 0;
  int acc_cnt;
  bit abort = 1'b0;
  bit apx_lat = 1'b0;
  logic [8:0] prev_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: frame statistics, protocol rules and scoreboard pop
  always @(negedge clk) begin
    exp_t e;
    if (!rstP) begin
      if (mul_state == 3'd0 && start) begin
        for (int i = 0; i < 8; i++) st_cnt[i] = 0;
        done_cnt = 0; res_cnt = 0; last_cnt = 0; vld_cnt = 0;
        apx_lat  = apx_cfg;
      end
      st_cnt[mul_state]++;
      if (done) done_cnt++;
      if (mul_vld) vld_cnt++;
      if (mul_racc != (mul_state == 3'd0)) apx_err++;
      if (mul_rapx != (apx_lat && (mul_state >= 3'd2) && (mul_state <= 3'd4))) apx_err++;
      if (mul_state >= 3'd2 && mul_state <= 3'd4) begin
        if ((mul_count0 != prev_cnt) != mul_vld) vld_err++;
        if (mul_vld && mul_count0 != ((prev_cnt == 9'd63) ? 9'd0 : prev_cnt + 9'd1)) vld_err++;
      end else if (mul_vld) begin
        vld_err++;
      end
      if (res_valid && res_ready) begin
        res_cnt++;
        if (res_last) last_cnt++;
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got 0x%0h, expected none", res_data);
        end else begin
          e = sb_q.pop_front();
          chk("res_data", 64'(res_data), 64'(e.data));
          chk("res_last", 64'(res_last), 64'(e.last));
        end
      end
    end
    prev_cnt = mul_count0;
  end

  task automatic check_reset();
    chk("rst_state", 64'(mul_state), 64'd0);
    chk("rst_count0", 64'(mul_count0), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    chk("rst_racc", 64'(mul_racc), 64'd1);
    chk("rst_rapx", 64'(mul_rapx), 64'd0);
    chk("rst_vld", 64'(mul_vld), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
  endtask

  task automatic start_frame(input bit apx);
    @(posedge clk); #1;
    start = 1'b1; apx_cfg = apx; acc_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Sends 16 groups of 8 pairs; expected result queued when a group's 8th pair is accepted
  task automatic send_frame(input bit bubbles);
    bit ok;
    int n;
    for (int g = 0; g < 16; g++) begin
      for (int k = 0; k < 8; k++) begin
        if (bubbles) begin
          in_valid = 1'b0;
          @(posedge clk); #1;
        end
        if (abort) begin in_valid = 1'b0; return; end
        in_a = tbl[g & 7].a; in_b = tbl[g & 7].b; in_valid = 1'b1;
        n = 0;
        do begin
          @(negedge clk);
          ok = in_ready;
          n++;
          @(posedge clk); #1;
        end while (!ok && n < 500 && !abort);
        if (abort) begin in_valid = 1'b0; return; end
        if (!ok) begin
          n_tests++; n_fail++;
          $display("FAIL accept_timeout: got no in_ready in %0d cycles, expected accept of pair %0d",
                   n, g * 8 + k);
          in_valid = 1'b0;
          return;
        end
        acc_cnt++;
        if (k == 7) sb_q.push_back('{data: tbl[g & 7].exp, last: (g == 15)});
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 2000) begin @(negedge clk); n++; end
    chk("done_seen", 64'(done), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_results"}, 64'(res_cnt), 64'd16);
    chk({tag, "_last_count"}, 64'(last_cnt), 64'd1);
    chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, "_issues"}, 64'(vld_cnt), 64'd128);
    chk({tag, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
    chk({tag, "_prime_cycles"}, 64'(st_cnt[1]), 64'd1);
  endtask

  initial begin
    int n, rv;
    tbl[0] = '{a: 16'sd1,      b: 16'sd1,      exp: 35'sd8};
    tbl[1] = '{a: -16'sd32768, b: -16'sd32768, exp: 35'sh200000000};
    tbl[2] = '{a: -16'sd1,     b: 16'sd3,      exp: -35'sd24};
    tbl[3] = '{a: 16'sd100,    b: -16'sd7,     exp: -35'sd5600};
    tbl[4] = '{a: 16'sd32767,  b: 16'sd32767,  exp: 35'sd8589410312};
    tbl[5] = '{a: -16'sd32768, b: 16'sd32767,  exp: -35'sd8589672448};
    tbl[6] = '{a: 16'sd0,      b: 16'sd12345,  exp: 35'sd0};
    tbl[7] = '{a: 16'sd255,    b: -16'sd256,   exp: -35'sd522240};

    rstP = 1'b1; start = 1'b0; apx_cfg = 1'b0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstP = 1'b0;
    @(negedge clk);
    check_reset();

    // Full frame, no stalls; state sequence 001, 010 x64, 011 x64, 100
    start_frame(1'b1);
    send_frame(1'b0);
    wait_done();
    check_frame("plain");
    chk("plain_row_cycles", 64'(st_cnt[2]), 64'd64);
    chk("plain_col_cycles", 64'(st_cnt[3]), 64'd64);
    chk("plain_drain_seen", 64'(st_cnt[4] > 0), 64'd1);

    // Consumer stalled: two results buffered, issue stops after 16 pairs
    res_ready = 1'b0;
    start_frame(1'b0);
    fork
      send_frame(1'b0);
      begin
        repeat (60) @(negedge clk);
        chk("bp_accepts", 64'(acc_cnt), 64'd16);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_res_valid", 64'(res_valid), 64'd1);
        chk("bp_head_hold", 64'(res_data), 64'(tbl[0].exp));
        chk("bp_buffered", 64'(sb_q.size()), 64'd2);
        @(posedge clk); #1;
        res_ready = 1'b1;
      end
    join
    wait_done();
    check_frame("bp");

    // Bubbles between every pair
    start_frame(1'b1);
    send_frame(1'b1);
    wait_done();
    check_frame("bubble");

    // Reset mid-ROW with products in flight
    start_frame(1'b0);
    fork
      send_frame(1'b0);
      begin
        n = 0;
        while (!(mul_state == 3'd2 && mul_count0 == 9'd20) && n < 500) begin
          @(negedge clk); n++;
        end
        chk("midrst_reached", 64'(mul_count0), 64'd20);
        @(posedge clk); #1;
        abort = 1'b1; rstP = 1'b1;
        @(posedge clk); #1;
        rstP = 1'b0;
        @(negedge clk);
        check_reset();
        rv = 0;
        repeat (10) begin @(negedge clk); if (res_valid) rv++; end
        chk("midrst_no_res_valid", 64'(rv), 64'd0);
      end
    join
    sb_q.delete();
    abort = 1'b0;
    start_frame(1'b0);
    send_frame(1'b0);
    wait_done();
    check_frame("after_rst");

    // start pulsed during COL must be ignored
    start_frame(1'b1);
    fork
      send_frame(1'b0);
      begin
        n = 0;
        while (mul_state != 3'd3 && n < 500) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    join
    wait_done();
    check_frame("col_start");
    chk("col_start_col_cycles", 64'(st_cnt[3]), 64'd64);
    repeat (5) @(negedge clk);
    chk("col_start_idle", 64'(busy), 64'd0);
    chk("col_start_single_done", 64'(done_cnt), 64'd1);

    chk("count0_vld_rule", 64'(vld_err), 64'd0);
    chk("racc_rapx_rule", 64'(apx_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
